hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit_pkg.sv | 17 +
 rtl/hazard_stall_unit_counter.sv | 42 ++++
 rtl/hazard_stall_unit.sv | 110 +++++++++++
 tb/tb_hazard_stall_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the hazard/stall unit: default widths and the
// multiply-sequencing FSM state encoding.
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_W_DEF = 5;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL1 = 2'd1,
        ST_MUL2 = 2'd2
    } hz_state_e;

endpackage : hazard_pkg

// File: rtl/hazard_stall_unit_counter.sv
// -----------------------------------------------------------------------------
// stall_counter
// Saturating up-counter of stall cycles. Clear wins over increment; the count
// holds at all-ones once reached.
//
// Ports
//   clk     in   rising-edge clock
//   arst_n  in   asynchronous active-low reset (count -> 0)
//   inc     in   count this cycle
//   clr     in   synchronous clear
//   count   out  current count (CNT_W bits)
// -----------------------------------------------------------------------------
module stall_counter
    import hazard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;
    logic             w_sat;

    assign w_sat = &r_count;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !w_sat) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : stall_counter

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// Pipeline hazard controller: load-use interlock, taken-branch flush and a
// 3-cycle multiply stall, plus a saturating count of PC-stall cycles.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no multiply in flight; a multiply in EX starts the stall here
//   MUL1  | second multiply cycle, front end still frozen
//   MUL2  | final multiply cycle, result lands in EX/MEM, front end released
//
// Ports
//   clk, arst_n                    clock / async active-low reset
//   IFID_Rs1, IFID_Rs2             source registers of the ID instruction
//   IDEX_Rd, IDEX_MemRead          destination / load flag of EX instruction
//   IDEX_Mult                      EX instruction is a multiply
//   Branch_Taken                   EX resolved a taken branch/jump
//   Cnt_Clear                      synchronous clear of Stall_Cnt
//   PC_Write, IFID_Write           front-end enables
//   IFID_Flush                     zero IF/ID
//   IDEX_Write, IDEX_Bubble        ID/EX enable / NOP insert
//   EXMEM_Bubble                   NOP into EX/MEM while multiply busy
//   Mult_Busy                      multiply occupying EX, result not valid
//   Stall_Cnt                      saturating count of PC_Write=0 cycles
// -----------------------------------------------------------------------------
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [REG_W-1:0] IFID_Rs1,
    input  logic [REG_W-1:0] IFID_Rs2,
    input  logic [REG_W-1:0] IDEX_Rd,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_Mult,
    input  logic             Branch_Taken,
    input  logic             Cnt_Clear,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Write,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Bubble,
    output logic             Mult_Busy,
    output logic [CNT_W-1:0] Stall_Cnt
);

    hz_state_e r_state;

    logic w_mult_stall;
    logic w_load_use;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (IDEX_Mult) r_state <= ST_MUL1;
                ST_MUL1: r_state <= ST_MUL2;
                ST_MUL2: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The stall covers the issue cycle and MUL1; MUL2 already lets the next
    // instruction advance since the result is captured at the end of MUL2.
    assign w_mult_stall = ((r_state == ST_IDLE) && IDEX_Mult) || (r_state == ST_MUL1);

    assign w_load_use = IDEX_MemRead && (IDEX_Rd != '0) &&
                        ((IDEX_Rd == IFID_Rs1) || (IDEX_Rd == IFID_Rs2));

    always_comb begin
        PC_Write     = 1'b1;
        IFID_Write   = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Write   = 1'b1;
        IDEX_Bubble  = 1'b0;
        EXMEM_Bubble = 1'b0;
        Mult_Busy    = 1'b0;
        if (w_mult_stall) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Bubble = 1'b1;
            Mult_Busy    = 1'b1;
        end else if (Branch_Taken) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else if (w_load_use) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end
    end

    stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (~PC_Write),
        .clr    (Cnt_Clear),
        .count  (Stall_Cnt)
    );

endmodule : hazard_stall_unit

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [4:0]  IFID_Rs1, IFID_Rs2, IDEX_Rd;
    logic        IDEX_MemRead, IDEX_Mult, Branch_Taken, Cnt_Clear;
    logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Write;
    logic        IDEX_Bubble, EXMEM_Bubble, Mult_Busy;
    logic [15:0] Stall_Cnt;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    hazard_stall_unit dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .IFID_Rs1     (IFID_Rs1),
        .IFID_Rs2     (IFID_Rs2),
        .IDEX_Rd      (IDEX_Rd),
        .IDEX_MemRead (IDEX_MemRead),
        .IDEX_Mult    (IDEX_Mult),
        .Branch_Taken (Branch_Taken),
        .Cnt_Clear    (Cnt_Clear),
        .PC_Write     (PC_Write),
        .IFID_Write   (IFID_Write),
        .IFID_Flush   (IFID_Flush),
        .IDEX_Write   (IDEX_Write),
        .IDEX_Bubble  (IDEX_Bubble),
        .EXMEM_Bubble (EXMEM_Bubble),
        .Mult_Busy    (Mult_Busy),
        .Stall_Cnt    (Stall_Cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks all seven control outputs against
    // {PC_Write,IFID_Write,IFID_Flush,IDEX_Write,IDEX_Bubble,EXMEM_Bubble,Mult_Busy}
    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, PC_Write, IFID_Write, IFID_Flush, IDEX_Write,
                  IDEX_Bubble, EXMEM_Bubble, Mult_Busy}, {25'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        IFID_Rs1 = '0; IFID_Rs2 = '0; IDEX_Rd = '0;
        IDEX_MemRead = 0; IDEX_Mult = 0; Branch_Taken = 0; Cnt_Clear = 0;
    endtask

    // control patterns: PC IFW IFF IDW IDB EXB MB
    localparam logic [6:0] C_IDLE = 7'b1101000;
    localparam logic [6:0] C_LU   = 7'b0001100;
    localparam logic [6:0] C_BR   = 7'b1111100;
    localparam logic [6:0] C_MUL  = 7'b0000011;

    initial begin
        clr_in();
        arst_n = 0;
        #12;
        chk_ctl("reset_ctl", C_IDLE);
        chk("reset_cnt", Stall_Cnt, 0);
        tick();
        arst_n = 1;
        #1;
        chk_ctl("idle_ctl", C_IDLE);
        tick();
        chk("idle_cnt", Stall_Cnt, 0);

        // load-use on rs2
        IDEX_MemRead = 1; IDEX_Rd = 5; IFID_Rs2 = 5; IFID_Rs1 = 3;
        #1;
        chk_ctl("lu_ctl", C_LU);
        tick();
        chk("lu_cnt", Stall_Cnt, 1);
        clr_in();
        #1;
        chk_ctl("lu_release", C_IDLE);
        tick();
        chk("lu_cnt_hold", Stall_Cnt, 1);

        // load to x0 never stalls
        IDEX_MemRead = 1; IDEX_Rd = 0; IFID_Rs1 = 0;
        #1;
        chk_ctl("ldx0_ctl", C_IDLE);
        tick();
        chk("ldx0_cnt", Stall_Cnt, 1);

        // clear beats increment
        IDEX_MemRead = 1; IDEX_Rd = 7; IFID_Rs1 = 7; Cnt_Clear = 1;
        #1;
        chk_ctl("clr_lu_ctl", C_LU);
        tick();
        chk("clr_cnt", Stall_Cnt, 0);
        Cnt_Clear = 0;

        // branch outranks load-use
        Branch_Taken = 1;
        #1;
        chk_ctl("br_ctl", C_BR);
        tick();
        chk("br_cnt", Stall_Cnt, 0);
        clr_in();

        // multiply: issue in IDLE, MUL1 with branch+load-use, release in MUL2
        IDEX_Mult = 1;
        #1;
        chk_ctl("mul_idle_ctl", C_MUL);
        tick();
        chk("mul_cnt1", Stall_Cnt, 1);
        IDEX_Mult = 0; Branch_Taken = 1;
        IDEX_MemRead = 1; IDEX_Rd = 9; IFID_Rs1 = 9;
        #1;
        chk_ctl("mul1_prio_ctl", C_MUL);
        tick();
        chk("mul_cnt2", Stall_Cnt, 2);
        clr_in();
        #1;
        chk_ctl("mul2_release", C_IDLE);
        tick();
        chk("mul_cnt_end", Stall_Cnt, 2);

        // back-to-back: Mult held through MUL2 is ignored there, reissues in IDLE
        IDEX_Mult = 1;
        tick();
        tick();
        #1;
        chk_ctl("b2b_mul2_ctl", C_IDLE);
        tick();
        Branch_Taken = 1;
        #1;
        chk_ctl("b2b_reissue_brmul", C_MUL);
        tick();
        clr_in();
        #1;
        chk_ctl("b2b_mul1", C_MUL);
        tick();
        #1;
        chk_ctl("b2b_mul2", C_IDLE);
        chk("b2b_cnt", Stall_Cnt, 6);
        tick();

        // reset in MUL1
        IDEX_Mult = 1;
        tick();
        IDEX_Mult = 0;
        #1;
        chk_ctl("pre_rst_mul1", C_MUL);
        chk("pre_rst_cnt", Stall_Cnt, 7);
        #1;
        arst_n = 0;
        #1;
        chk_ctl("rst_mid_ctl", C_IDLE);
        chk("rst_mid_cnt", Stall_Cnt, 0);
        tick();
        arst_n = 1;
        #1;
        chk_ctl("post_rst_ctl", C_IDLE);
        tick();
        chk_ctl("post_rst_ctl2", C_IDLE);
        chk("post_rst_cnt", Stall_Cnt, 0);

        // saturation via a held load-use
        IDEX_MemRead = 1; IDEX_Rd = 4; IFID_Rs1 = 4;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_minus1", Stall_Cnt, 16'hFFFE);
        tick();
        chk("sat_reach", Stall_Cnt, 16'hFFFF);
        tick();
        chk("sat_hold", Stall_Cnt, 16'hFFFF);
        Cnt_Clear = 1;
        tick();
        chk("sat_clear", Stall_Cnt, 0);
        clr_in();
        tick();
        chk("final_cnt", Stall_Cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_hazard_stall_unit
